// File: rtl/spi_pkg.sv
// Purpose : opcodes and FSM state encoding shared by the SPI burst-RAM slave.
// Latency : n/a, declarations only.
// Backpr. : n/a.
package spi_pkg;

   // 2-bit opcode sent first in every frame, MSB first.
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_WR_ADDR = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_DATA = 3'd5,
      ST_DRAIN   = 3'd6
   } state_t;

endpackage

// File: rtl/spi_sp_ram.sv
// Purpose : single-port RAM, synchronous write, registered read.
// Latency : write lands on the edge with we=1; dout holds mem[addr] one edge later.
// Backpr. : none; one access per cycle, read every cycle.
// Ports   : clk, we (write enable), addr, din (write data), dout (registered read data).
module spi_sp_ram #(
   parameter int DEPTH      = 256,
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset. Read-during-write returns the old word;
   // the slave never reads the address it is writing.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/spi_slave_burst_ram.sv
// Purpose : SPI-framed slave (system-clock sampled) over an internal RAM with auto-incrementing bursts.
// Latency : writes commit on the last bit edge; read MSB appears on MISO 2 edges after the op[0] edge.
// Backpr. : none; host paces the stream, read words stream back-to-back with a 1-word prefetch.
// Ports   : clk, rst (sync, active-high), SS_n (frame select, active-low), MOSI (serial in),
//           MISO (registered serial out), busy (FSM outside IDLE).
module spi_slave_burst_ram
   import spi_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 2**ADDR_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy
);

   localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAXW + 1);

   localparam logic [CNT_W-1:0]      ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
   localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);

   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Folds an out-of-range host address back into the populated RAM.
   function automatic logic [ADDR_WIDTH-1:0] ptr_load(input logic [ADDR_WIDTH-1:0] a);
      return ADDR_WIDTH'(32'(a) % 32'(MEM_DEPTH));
   endfunction

   state_t                state_q;
   logic                  op1_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [MAXW-2:0]       rx_q;      // previously received bits; the current MOSI completes rx_d
   logic [MAXW-1:0]       rx_d;
   logic [DATA_WIDTH-1:0] tx_q;
   logic                  tx_vld_q;  // tx_q holds a word (first RD_DATA edge only loads it)
   logic                  miso_q;
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_dout;

   assign rx_d = {rx_q, MOSI};

   // In CMD the RAM reads rd_ptr so a read burst has its first word ready on the next
   // edge; inside RD_DATA it keeps reading rd_ptr+1, which is the prefetch for the
   // word after the one being shifted.
   always_comb begin
      ram_addr = rd_ptr_q;
      if (state_q == ST_WR_DATA) begin
         ram_addr = wr_ptr_q;
      end else if (state_q == ST_RD_DATA) begin
         ram_addr = ptr_inc(rd_ptr_q);
      end
      ram_we = (state_q == ST_WR_DATA) && !SS_n && !rst && (cnt_q == DATA_LAST);
   end

   spi_sp_ram #(
      .DEPTH      (MEM_DEPTH),
      .WIDTH      (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (rx_d[DATA_WIDTH-1:0]),
      .dout (ram_dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op1_q    <= 1'b0;
         cnt_q    <= '0;
         rx_q     <= '0;
         tx_q     <= '0;
         tx_vld_q <= 1'b0;
         miso_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (SS_n) begin
         // Deselect ends the frame; a partial word dies with the counter.
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         tx_vld_q <= 1'b0;
         miso_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               op1_q   <= MOSI;
               state_q <= ST_CMD;
            end
            ST_CMD: begin
               cnt_q    <= '0;
               tx_vld_q <= 1'b0;
               case ({op1_q, MOSI})
                  OP_WR_ADDR: state_q <= ST_WR_ADDR;
                  OP_WR_DATA: state_q <= ST_WR_DATA;
                  OP_RD_ADDR: state_q <= ST_RD_ADDR;
                  default:    state_q <= ST_RD_DATA;
               endcase
            end
            ST_WR_ADDR, ST_RD_ADDR: begin
               rx_q <= rx_d[MAXW-2:0];
               if (cnt_q == ADDR_LAST) begin
                  if (state_q == ST_WR_ADDR) begin
                     wr_ptr_q <= ptr_load(rx_d[ADDR_WIDTH-1:0]);
                  end else begin
                     rd_ptr_q <= ptr_load(rx_d[ADDR_WIDTH-1:0]);
                  end
                  state_q <= ST_DRAIN;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WR_DATA: begin
               rx_q <= rx_d[MAXW-2:0];
               if (cnt_q == DATA_LAST) begin
                  // The RAM write itself is driven combinationally on this edge.
                  wr_ptr_q <= ptr_inc(wr_ptr_q);
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RD_DATA: begin
               if (!tx_vld_q) begin
                  tx_q     <= ram_dout;
                  tx_vld_q <= 1'b1;
                  cnt_q    <= '0;
                  miso_q   <= 1'b0;
               end else begin
                  miso_q <= tx_q[DATA_WIDTH-1];
                  if (cnt_q == DATA_LAST) begin
                     // Last bit of this word goes out now: swap in the prefetched
                     // word and count this one as delivered.
                     tx_q     <= ram_dout;
                     cnt_q    <= '0;
                     rd_ptr_q <= ptr_inc(rd_ptr_q);
                  end else begin
                     tx_q  <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               // Surplus bits after an address are ignored until deselect.
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign MISO = miso_q;
   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_burst_ram.sv
// Purpose : self-checking bench for spi_slave_burst_ram (default and 10/16-bit instances).
// Latency : checks MISO bit-by-bit from the 2nd edge after op[0] against a frame-level RAM model.
// Backpr. : n/a; the bench drives SS_n/MOSI as the host.
module tb_spi_slave_burst_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, ss0, mosi0, miso0, busy0;
   logic rst1, ss1, mosi1, miso1, busy1;

   spi_slave_burst_ram dut0 (
      .clk (clk), .rst (rst0), .SS_n (ss0), .MOSI (mosi0), .MISO (miso0), .busy (busy0)
   );

   spi_slave_burst_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut1 (
      .clk (clk), .rst (rst1), .SS_n (ss1), .MOSI (mosi1), .MISO (miso1), .busy (busy1)
   );

   int checks = 0;
   int errors = 0;

   // Frame-level reference model: per instance RAM image, known-mask and pointers.
   int         depth [2] = '{256, 1024};
   int         aw    [2] = '{8, 10};
   int         dw    [2] = '{8, 16};
   logic [15:0] mem_m [2][1024];
   bit          known [2][1024];
   int          wr_p  [2];
   int          rd_p  [2];
   int          last_wa [2];
   bit          pl_q  [$];   // host payload bits for the next frame, MSB first
   bit          got_q [$];   // MISO bits captured during the last read frame

   typedef struct {
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int s, input logic ss, input logic mo, input logic r);
      if (s == 0) begin ss0 = ss; mosi0 = mo; rst0 = r; end
      else        begin ss1 = ss; mosi1 = mo; rst1 = r; end
   endtask

   function automatic logic out_miso(input int s);
      return (s == 0) ? miso0 : miso1;
   endfunction

   function automatic logic out_busy(input int s);
      return (s == 0) ? busy0 : busy1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) pl_q.push_back(v[i]);
   endtask

   function automatic int pl_val(input int start, input int n);
      int v;
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 1) | int'(pl_q[start + i]);
      return v;
   endfunction

   function automatic logic [31:0] got_word(input int s, input int k);
      logic [31:0] v;
      int idx;
      v = '0;
      for (int i = 0; i < dw[s]; i++) begin
         idx = k * dw[s] + i;
         v = {v[30:0], (idx < got_q.size()) ? got_q[idx] : 1'b0};
      end
      return v;
   endfunction

   // One SS_n-framed transaction. Writes send pl_q; reads run nsteps edges after op[0]
   // with random MOSI. rst_at >= 0 pulses rst on that payload edge with SS_n still low.
   task automatic frame(input int s, input logic [1:0] op, input int nsteps, input int rst_at);
      bit   exp_b [$];
      bit   exp_k [$];
      int   n;
      int   a;
      bit   aborted;
      logic mo;
      n = (op == 2'b11) ? nsteps : pl_q.size();
      aborted = 1'b0;
      got_q.delete();
      if (op == 2'b11) begin
         for (int w = 0; w * dw[s] < n; w++) begin
            a = (rd_p[s] + w) % depth[s];
            for (int i = dw[s] - 1; i >= 0; i--) begin
               exp_b.push_back(mem_m[s][a][i]);
               exp_k.push_back(known[s][a]);
            end
         end
      end
      drive(s, 1'b0, op[1], 1'b0);
      step();
      check($sformatf("d%0d_busy_after_op1", s), 32'(out_busy(s)), 32'd1);
      drive(s, 1'b0, op[0], 1'b0);
      step();
      check($sformatf("d%0d_miso_after_op0", s), 32'(out_miso(s)), 32'd0);
      for (int j = 0; j < n; j++) begin
         mo = (op != 2'b11) ? pl_q[j] : 1'($urandom_range(0, 1));
         drive(s, 1'b0, mo, (j == rst_at));
         step();
         if (j == rst_at) begin
            check($sformatf("d%0d_rst_miso", s), 32'(out_miso(s)), 32'd0);
            check($sformatf("d%0d_rst_busy", s), 32'(out_busy(s)), 32'd0);
            wr_p[s] = 0;
            rd_p[s] = 0;
            aborted = 1'b1;
            break;
         end
         check($sformatf("d%0d_busy_op%0d_e%0d", s, op, j), 32'(out_busy(s)), 32'd1);
         if (op == 2'b11) begin
            if (j == 0) begin
               check($sformatf("d%0d_miso_prefetch", s), 32'(out_miso(s)), 32'd0);
            end else begin
               got_q.push_back(out_miso(s));
               if (exp_k[j-1])
                  check($sformatf("d%0d_miso_bit%0d", s, j - 1), 32'(out_miso(s)), 32'(exp_b[j-1]));
            end
         end else begin
            check($sformatf("d%0d_miso_quiet_op%0d", s, op), 32'(out_miso(s)), 32'd0);
         end
      end
      drive(s, 1'b1, 1'b0, 1'b0);
      step();
      check($sformatf("d%0d_busy_after_ss", s), 32'(out_busy(s)), 32'd0);
      check($sformatf("d%0d_miso_after_ss", s), 32'(out_miso(s)), 32'd0);
      if (!aborted) begin
         case (op)
            2'b00: if (n >= aw[s]) wr_p[s] = pl_val(0, aw[s]) % depth[s];
            2'b10: if (n >= aw[s]) rd_p[s] = pl_val(0, aw[s]) % depth[s];
            2'b01: begin
               for (int w = 0; w < n / dw[s]; w++) begin
                  mem_m[s][wr_p[s]] = 16'(pl_val(w * dw[s], dw[s]));
                  known[s][wr_p[s]] = 1'b1;
                  wr_p[s] = (wr_p[s] + 1) % depth[s];
               end
            end
            default: if (n >= 1) rd_p[s] = (rd_p[s] + (n - 1) / dw[s]) % depth[s];
         endcase
      end
      pl_q.delete();
   endtask

   task automatic t_wa(input int s, input int a);
      push_bits(a, aw[s]);
      frame(s, 2'b00, 0, -1);
   endtask

   task automatic t_ra(input int s, input int a);
      push_bits(a, aw[s]);
      frame(s, 2'b10, 0, -1);
   endtask

   task automatic t_rd(input int s, input int nwords);
      frame(s, 2'b11, nwords * dw[s] + 1, -1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: no finish within 1000000 time units");
      $fatal(1);
   end

   int s, r, a, nw;

   initial begin
      vecs[0] = '{8'h69, 8'hB3, 8'hB3};
      vecs[1] = '{8'h00, 8'h5A, 8'h5A};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{8'h80, 8'h00, 8'h00};
      vecs[4] = '{8'h01, 8'h81, 8'h81};
      vecs[5] = '{8'h7E, 8'h3C, 8'h3C};
      vecs[6] = '{8'h69, 8'h0F, 8'h0F};
      wr_p = '{0, 0};
      rd_p = '{0, 0};
      last_wa = '{0, 0};

      // Reset state.
      drive(0, 1'b1, 1'b0, 1'b1);
      drive(1, 1'b1, 1'b0, 1'b1);
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("d%0d_reset_miso", k), 32'(out_miso(k)), 32'd0);
         check($sformatf("d%0d_reset_busy", k), 32'(out_busy(k)), 32'd0);
      end
      drive(0, 1'b1, 1'b0, 1'b0);
      drive(1, 1'b1, 1'b0, 1'b0);
      step();

      // Table: single-word write then read-back (entry 0 is the classic 0x69/0xB3 case).
      for (int i = 0; i < 7; i++) begin
         t_wa(0, int'(vecs[i].addr));
         push_bits(32'(vecs[i].wdata), 8);
         frame(0, 2'b01, 0, -1);
         t_ra(0, int'(vecs[i].addr));
         t_rd(0, 1);
         check($sformatf("vec%0d_readback", i), got_word(0, 0), 32'(vecs[i].exp));
      end

      // Burst write wrapping from 0xFF to 0x00, then gapless 3-word read.
      t_wa(0, 8'hFF);
      push_bits(8'h01, 8); push_bits(8'h02, 8); push_bits(8'h03, 8);
      frame(0, 2'b01, 0, -1);
      t_ra(0, 8'hFF);
      t_rd(0, 3);
      check("burst_w0", got_word(0, 0), 32'h01);
      check("burst_w1", got_word(0, 1), 32'h02);
      check("burst_w2", got_word(0, 2), 32'h03);

      // Reset during the 2nd word of a read burst: rd_ptr back to 0, RAM kept.
      t_ra(0, 8'hFF);
      frame(0, 2'b11, 3 * 8 + 1, 12);
      t_rd(0, 1);
      check("post_rst_rd_ptr0", got_word(0, 0), 32'h02);
      t_ra(0, 8'hFF);
      t_rd(0, 1);
      check("post_rst_ram_kept", got_word(0, 0), 32'h01);

      // Abort after 5 of 8 data bits: no write, no pointer move.
      t_wa(0, 8'h20);
      push_bits(8'h5A, 8); push_bits(8'h66, 8);
      frame(0, 2'b01, 0, -1);
      t_wa(0, 8'h20);
      push_bits(5'b10101, 5);
      frame(0, 2'b01, 0, -1);
      t_ra(0, 8'h20);
      t_rd(0, 2);
      check("abort_ram_w0", got_word(0, 0), 32'h5A);
      check("abort_ram_w1", got_word(0, 1), 32'h66);
      push_bits(8'hC3, 8);
      frame(0, 2'b01, 0, -1);
      t_ra(0, 8'h20);
      t_rd(0, 2);
      check("abort_wr_ptr_kept", got_word(0, 0), 32'hC3);
      check("abort_neighbour", got_word(0, 1), 32'h66);

      // 12 address bits: only the first 8 are the address.
      push_bits(8'h3C, 8); push_bits(4'hF, 4);
      frame(0, 2'b00, 0, -1);
      push_bits(8'h99, 8);
      frame(0, 2'b01, 0, -1);
      t_ra(0, 8'h3C);
      t_rd(0, 1);
      check("extra_addr_bits", got_word(0, 0), 32'h99);

      // SS_n low for a single edge has no lasting effect.
      drive(0, 1'b0, 1'b1, 1'b0);
      step();
      check("short_ss_busy_hi", 32'(busy0), 32'd1);
      drive(0, 1'b1, 1'b0, 1'b0);
      step();
      check("short_ss_busy_lo", 32'(busy0), 32'd0);
      t_rd(0, 1);

      // 10-bit address / 16-bit data instance, wrapping burst.
      t_wa(1, 10'h3FF);
      push_bits(16'hA5C3, 16); push_bits(16'h1234, 16);
      frame(1, 2'b01, 0, -1);
      t_ra(1, 10'h3FF);
      t_rd(1, 2);
      check("wide_w0", got_word(1, 0), 32'hA5C3);
      check("wide_w1", got_word(1, 1), 32'h1234);

      // Randomised frames on both instances against the model.
      for (int it = 0; it < 80; it++) begin
         s = int'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         a = int'($urandom_range(0, depth[s] - 1));
         if (r < 2) begin
            last_wa[s] = a;
            push_bits(a, aw[s]);
            if ($urandom_range(0, 3) == 0) push_bits($urandom, int'($urandom_range(1, 5)));
            frame(s, 2'b00, 0, -1);
         end else if (r < 5) begin
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < nw; w++) push_bits($urandom, dw[s]);
            if ($urandom_range(0, 4) == 0) push_bits($urandom, int'($urandom_range(1, dw[s] - 1)));
            frame(s, 2'b01, 0, -1);
         end else if (r < 7) begin
            if ($urandom_range(0, 1) == 1) a = last_wa[s];
            push_bits(a, aw[s]);
            frame(s, 2'b10, 0, -1);
         end else begin
            frame(s, 2'b11, int'($urandom_range(0, 3 * dw[s] + 1)), -1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
